// File: rtl/uart_tx_frame.sv
// uart_tx_frame
//   UART transmitter. Serialises one parallel word per valid/ready handshake
//   into an asynchronous frame: start bit, DATA_BITS data bits LSB first,
//   optional parity bit, then STOP_BITS stop bits, on a registered tx_out.
//
//   state    | meaning
//   ---------+----------------------------------------------------------
//   S_IDLE   | line at mark, tx_ready high, waiting for tx_valid
//   S_START  | driving the start bit (0)
//   S_DATA   | driving data bits, LSB first; bit_cnt = index of bit on line
//   S_PARITY | driving the parity bit computed from the latched word
//   S_STOP   | driving stop bit(s) (1); bit_cnt = stop bit index
//
// Ports
//   clk       in   system clock, rising edge
//   rst       in   asynchronous, active-high reset
//   tx_data   in   word to send, sampled only on accept
//   tx_valid  in   host has a word
//   tx_ready  out  block can accept (accept = tx_valid & tx_ready at posedge)
//   tx_out    out  serial line, idle high, driven from a flop
//   tx_busy   out  frame in progress (= ~tx_ready)
//   tx_done   out  one-cycle pulse after the last stop bit
module uart_tx_frame #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx_out,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);
  localparam logic          ODD       = (PARITY_ODD != 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t                 state, state_n;
  logic [BW-1:0]          baud_cnt, baud_cnt_n;
  logic [3:0]             bit_cnt, bit_cnt_n;
  logic [DATA_BITS-1:0]   shift_reg, shift_reg_n;
  logic                   parity_bit, parity_bit_n;
  logic                   tx_out_n;
  logic                   tx_done_n;
  logic                   baud_wrap;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      baud_cnt   <= '0;
      bit_cnt    <= '0;
      shift_reg  <= '0;
      parity_bit <= 1'b0;
      tx_out     <= 1'b1;
      tx_done    <= 1'b0;
    end else begin
      state      <= state_n;
      baud_cnt   <= baud_cnt_n;
      bit_cnt    <= bit_cnt_n;
      shift_reg  <= shift_reg_n;
      parity_bit <= parity_bit_n;
      tx_out     <= tx_out_n;
      tx_done    <= tx_done_n;
    end
  end

  assign baud_wrap = (baud_cnt == BAUD_LAST);

  // The next line value is decided at each bit boundary and registered, so
  // tx_out changes exactly on the edge that starts the next bit.
  always_comb begin
    state_n      = state;
    baud_cnt_n   = baud_cnt;
    bit_cnt_n    = bit_cnt;
    shift_reg_n  = shift_reg;
    parity_bit_n = parity_bit;
    tx_out_n     = tx_out;
    tx_done_n    = 1'b0;

    if (state != S_IDLE) begin
      baud_cnt_n = baud_wrap ? '0 : baud_cnt + 1'b1;
    end

    case (state)
      S_IDLE: begin
        if (tx_valid) begin
          state_n      = S_START;
          shift_reg_n  = tx_data;
          parity_bit_n = (^tx_data) ^ ODD;
          tx_out_n     = 1'b0;
          baud_cnt_n   = '0;
          bit_cnt_n    = '0;
        end
      end
      S_START: begin
        if (baud_wrap) begin
          state_n     = S_DATA;
          bit_cnt_n   = '0;
          tx_out_n    = shift_reg[0];
          shift_reg_n = shift_reg >> 1;
        end
      end
      S_DATA: begin
        if (baud_wrap) begin
          if (bit_cnt == DATA_LAST) begin
            bit_cnt_n = '0;
            if (PARITY_EN != 0) begin
              state_n  = S_PARITY;
              tx_out_n = parity_bit;
            end else begin
              state_n  = S_STOP;
              tx_out_n = 1'b1;
            end
          end else begin
            bit_cnt_n   = bit_cnt + 1'b1;
            tx_out_n    = shift_reg[0];
            shift_reg_n = shift_reg >> 1;
          end
        end
      end
      S_PARITY: begin
        if (baud_wrap) begin
          state_n   = S_STOP;
          bit_cnt_n = '0;
          tx_out_n  = 1'b1;
        end
      end
      S_STOP: begin
        if (baud_wrap) begin
          if (bit_cnt == STOP_LAST) begin
            state_n   = S_IDLE;
            bit_cnt_n = '0;
            tx_out_n  = 1'b1;
            tx_done_n = 1'b1;
          end else begin
            bit_cnt_n = bit_cnt + 1'b1;
          end
        end
      end
      default: begin
        state_n  = S_IDLE;
        tx_out_n = 1'b1;
      end
    endcase
  end

  assign tx_ready = (state == S_IDLE);
  assign tx_busy  = ~tx_ready;

endmodule

// File: tb/tb_uart_tx_frame.sv
// tb_uart_tx_frame
//   Four instances of uart_tx_frame with different parameter sets share one
//   clock and reset. Each frame is checked cycle by cycle against a reference
//   built from the frame rules: bit slot j of a frame is start/data/parity/stop
//   depending on j, and each slot lasts CLKS_PER_BIT cycles.
module tb_uart_tx_frame;

  logic       clk;
  logic       rst;
  logic       tx_valid_v [4];
  logic [8:0] tx_data_v  [4];
  logic       tx_ready_v [4];
  logic       tx_out_v   [4];
  logic       tx_busy_v  [4];
  logic       tx_done_v  [4];

  int cfg_db  [4] = '{8, 8, 8, 5};
  int cfg_pe  [4] = '{0, 1, 1, 0};
  int cfg_odd [4] = '{0, 0, 1, 0};
  int cfg_sb  [4] = '{1, 1, 1, 2};
  int cfg_cpb [4] = '{4, 4, 4, 2};

  int n_checks = 0;
  int n_fail   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  uart_tx_frame #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_8n1 (
    .clk(clk), .rst(rst), .tx_data(tx_data_v[0][7:0]), .tx_valid(tx_valid_v[0]),
    .tx_ready(tx_ready_v[0]), .tx_out(tx_out_v[0]), .tx_busy(tx_busy_v[0]), .tx_done(tx_done_v[0]));

  uart_tx_frame #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u_8e1 (
    .clk(clk), .rst(rst), .tx_data(tx_data_v[1][7:0]), .tx_valid(tx_valid_v[1]),
    .tx_ready(tx_ready_v[1]), .tx_out(tx_out_v[1]), .tx_busy(tx_busy_v[1]), .tx_done(tx_done_v[1]));

  uart_tx_frame #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u_8o1 (
    .clk(clk), .rst(rst), .tx_data(tx_data_v[2][7:0]), .tx_valid(tx_valid_v[2]),
    .tx_ready(tx_ready_v[2]), .tx_out(tx_out_v[2]), .tx_busy(tx_busy_v[2]), .tx_done(tx_done_v[2]));

  uart_tx_frame #(.CLKS_PER_BIT(2), .DATA_BITS(5), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) u_5n2 (
    .clk(clk), .rst(rst), .tx_data(tx_data_v[3][4:0]), .tx_valid(tx_valid_v[3]),
    .tx_ready(tx_ready_v[3]), .tx_out(tx_out_v[3]), .tx_busy(tx_busy_v[3]), .tx_done(tx_done_v[3]));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h, expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Expected line level for bit slot idx of a frame carrying word d on unit u.
  function automatic logic exp_bit(input int u, input logic [8:0] d, input int idx);
    int ones;
    if (idx == 0) return 1'b0;
    if (idx <= cfg_db[u]) return d[idx-1];
    if (cfg_pe[u] != 0 && idx == cfg_db[u] + 1) begin
      ones = 0;
      for (int b = 0; b < cfg_db[u]; b++) ones += int'(d[b]);
      return ((ones % 2) == 1) ^ (cfg_odd[u] != 0);
    end
    return 1'b1;
  endfunction

  // Sends word d on unit u and checks every cycle of the frame plus the done
  // cycle. keep_valid holds tx_valid high with next_d queued for a
  // back-to-back frame; pulse_at raises tx_valid for one busy cycle; noise
  // throws random tx_valid pulses at the busy block.
  task automatic send_check(input int u, input logic [8:0] d, input bit keep_valid,
                            input logic [8:0] next_d, input int pulse_at, input bit noise);
    int c, n, t;
    c = cfg_cpb[u];
    n = 1 + cfg_db[u] + cfg_pe[u] + cfg_sb[u];
    t = 0;
    while (tx_ready_v[u] !== 1'b1 && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) begin
      check("ready_wait_timeout", 32'd0, 32'd1);
      return;
    end
    tx_valid_v[u] = 1'b1;
    tx_data_v[u]  = d;
    @(posedge clk);
    for (int j = 0; j <= n * c; j++) begin
      @(negedge clk);
      if (j == n * c) begin
        check("done_pulse", 32'(tx_done_v[u]), 32'd1);
        check("ready_at_done", 32'(tx_ready_v[u]), 32'd1);
        check("busy_at_done", 32'(tx_busy_v[u]), 32'd0);
        check("mark_at_done", 32'(tx_out_v[u]), 32'd1);
        tx_valid_v[u] = keep_valid;
        tx_data_v[u]  = next_d;
      end else begin
        check($sformatf("u%0d_slot%0d_line", u, j / c), 32'(tx_out_v[u]), 32'(exp_bit(u, d, j / c)));
        check("ready_low", 32'(tx_ready_v[u]), 32'd0);
        check("busy_high", 32'(tx_busy_v[u]), 32'd1);
        check("no_early_done", 32'(tx_done_v[u]), 32'd0);
        if (keep_valid) begin
          tx_valid_v[u] = 1'b1;
          tx_data_v[u]  = next_d;
        end else begin
          tx_data_v[u]  = 9'($urandom);
          tx_valid_v[u] = (j == pulse_at) || (noise && $urandom_range(0, 3) == 0);
        end
      end
    end
    if (!keep_valid) begin
      @(negedge clk);
      check("done_width", 32'(tx_done_v[u]), 32'd0);
      check("idle_ready", 32'(tx_ready_v[u]), 32'd1);
      check("idle_mark", 32'(tx_out_v[u]), 32'd1);
    end
  endtask

  task automatic check_reset_state(input string tag);
    for (int u = 0; u < 4; u++) begin
      check({tag, "_out"}, 32'(tx_out_v[u]), 32'd1);
      check({tag, "_ready"}, 32'(tx_ready_v[u]), 32'd1);
      check({tag, "_busy"}, 32'(tx_busy_v[u]), 32'd0);
      check({tag, "_done"}, 32'(tx_done_v[u]), 32'd0);
    end
  endtask

  initial begin
    rst = 1'b1;
    for (int u = 0; u < 4; u++) begin
      tx_valid_v[u] = 1'b0;
      tx_data_v[u]  = '0;
    end
    #1;
    check_reset_state("por");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Reset while idle, asserted between edges: outputs must respond at once.
    rst = 1'b1;
    #1;
    check_reset_state("rst_idle");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset in the middle of the data bits of a frame on unit 0.
    tx_valid_v[0] = 1'b1;
    tx_data_v[0]  = 9'h05A;
    @(posedge clk);
    @(negedge clk);
    tx_valid_v[0] = 1'b0;
    repeat (10) @(negedge clk);
    check("mid_frame_busy", 32'(tx_busy_v[0]), 32'd1);
    rst = 1'b1;
    #1;
    check_reset_state("rst_data");
    @(negedge clk);
    rst = 1'b0;
    for (int j = 0; j < 45; j++) begin
      @(negedge clk);
      check("abandoned_no_done", 32'(tx_done_v[0]), 32'd0);
      check("abandoned_mark", 32'(tx_out_v[0]), 32'd1);
    end
    send_check(0, 9'h0A5, 1'b0, 9'h000, -1, 1'b0);

    // Busy ignore: a second word offered mid-frame never reaches the line.
    send_check(0, 9'h03C, 1'b0, 9'h0C3, 10, 1'b0);

    // Back-to-back with tx_valid held high across the done cycle.
    send_check(0, 9'h000, 1'b1, 9'h0FF, -1, 1'b0);
    send_check(0, 9'h0FF, 1'b0, 9'h000, -1, 1'b0);

    // Parity even / odd.
    send_check(1, 9'h0A5, 1'b0, 9'h000, -1, 1'b0);
    send_check(2, 9'h0A5, 1'b0, 9'h000, -1, 1'b0);
    send_check(1, 9'h007, 1'b0, 9'h000, -1, 1'b0);
    send_check(2, 9'h007, 1'b0, 9'h000, -1, 1'b0);

    // Five data bits, two stop bits, two clocks per bit.
    send_check(3, 9'h015, 1'b0, 9'h000, -1, 1'b0);

    // Random words with random tx_valid noise while busy, sometimes chained.
    for (int i = 0; i < 24; i++) begin
      int u;
      logic [8:0] w, w2;
      u  = i % 4;
      w  = 9'($urandom);
      w2 = 9'($urandom);
      if ($urandom_range(0, 2) == 0) begin
        send_check(u, w, 1'b1, w2, -1, 1'b0);
        send_check(u, w2, 1'b0, 9'h000, -1, 1'b1);
      end else begin
        send_check(u, w, 1'b0, 9'h000, -1, 1'b1);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
